// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/shift ops, plus an iterative
// shift-add multiply that keeps the unit busy for WIDTH cycles.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Unsigned magnitude compare packed as {lt, eq, gt}.
    function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        cmp3 = {a < b, a == b, a > b};
    endfunction

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept_s;
    logic             mul_last_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] step_s;
    logic [SHW-1:0]   shamt_s;
    logic [2:0]       cmp_in_s;
    logic [2:0]       cmp_cap_s;

    assign accept_s   = start && (state_q == S_IDLE);
    assign mul_last_s = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign sum_s      = {1'b0, x} + {1'b0, y};
    assign diff_s     = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    assign step_s     = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    assign shamt_s    = y[SHW-1:0];
    assign cmp_in_s   = cmp3(x, y);
    assign cmp_cap_s  = cmp3(x_q, y_q);

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {SHW{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            x_q      <= {WIDTH{1'b0}};
            y_q      <= {WIDTH{1'b0}};
            out_q    <= {WIDTH{1'b0}};
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            x_q      <= x_d;
            y_q      <= y_d;
            out_q    <= out_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: only a multiply leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (alu_op == OP_MUL)) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output updates; results hold unless a request completes.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        x_d      = x_q;
        y_d      = y_q;
        out_d    = out_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = (state_d == S_MUL);
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    x_d = x;
                    y_d = y;
                    if (alu_op == OP_MUL) begin
                        cnt_d    = {SHW{1'b0}};
                        acc_d    = {WIDTH{1'b0}};
                        mcand_d  = x;
                        mplier_d = y;
                    end else begin
                        {lt_d, eq_d, gt_d} = cmp_in_s;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        done_d  = 1'b1;
                        case (alu_op)
                            OP_AND: out_d = x & y;
                            OP_OR:  out_d = x | y;
                            OP_ADD: begin
                                out_d   = sum_s[WIDTH-1:0];
                                carry_d = sum_s[WIDTH];
                                ovf_d   = (x[WIDTH-1] == y[WIDTH-1]) &&
                                          (sum_s[WIDTH-1] != x[WIDTH-1]);
                            end
                            OP_SLT: out_d = {{(WIDTH-1){1'b0}}, cmp_in_s[2]};
                            OP_SLL: out_d = x << shamt_s;
                            OP_SRL: out_d = x >> shamt_s;
                            OP_SUB: begin
                                // carry set means no borrow, i.e. x >= y
                                out_d   = diff_s[WIDTH-1:0];
                                carry_d = diff_s[WIDTH];
                                ovf_d   = (x[WIDTH-1] != y[WIDTH-1]) &&
                                          (diff_s[WIDTH-1] != x[WIDTH-1]);
                            end
                            default: out_d = out_q;
                        endcase
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d    = step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (mul_last_s) begin
                    out_d              = step_s;
                    {lt_d, eq_d, gt_d} = cmp_cap_s;
                    carry_d            = 1'b0;
                    ovf_d              = 1'b0;
                    done_d             = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc at WIDTH=16, plus hand-written
// sequences for busy-ignore, back-to-back issue and reset abort.
module tb_alu_mc;

    localparam int W = 16;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   alu_op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         lt;
    logic         eq;
    logic         gt;
    logic         carry_out;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .x(x), .y(y),
        .busy(busy), .done(done), .out(out), .lt(lt), .eq(eq), .gt(gt),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         l;
        logic         e;
        logic         g;
        logic         c;
        logic         v;
        int           edges;   // clock edges after the accept edge until done rises
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a request at the falling edge; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_op = op;
        x      = a;
        y      = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int total;
        int seen;

        vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};
        vecs[2]  = '{OP_SLT, 16'h0003, 16'h0005, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{OP_SLL, 16'h0001, 16'h0013, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{OP_SRL, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[5]  = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[6]  = '{OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[8]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[10] = '{OP_MUL, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[11] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16};
        vecs[12] = '{OP_SLT, 16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[13] = '{OP_SLL, 16'h00FF, 16'h0028, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[14] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};

        // Reset, with a start held during reset that must be dropped.
        rst = 1'b1; start = 1'b1; alu_op = OP_ADD; x = 16'h0002; y = 16'h0003;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  {16'h0, out}, 32'h0);
        chk("rst_flags", {27'h0, lt, eq, gt, carry_out, overflow}, 32'h0);
        chk("rst_done_busy", {30'h0, done, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_ignored", {31'h0, done}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].op == OP_MUL) chk($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h1);
            x = ~vecs[i].a;
            y = ~vecs[i].b;
            wait_done(n);
            chk($sformatf("v%0d_edges", i), n, vecs[i].edges);
            chk($sformatf("v%0d_out", i), {16'h0, out}, {16'h0, vecs[i].res});
            chk($sformatf("v%0d_cmp", i), {29'h0, lt, eq, gt},
                {29'h0, vecs[i].l, vecs[i].e, vecs[i].g});
            chk($sformatf("v%0d_cv", i), {30'h0, carry_out, overflow},
                {30'h0, vecs[i].c, vecs[i].v});
            chk($sformatf("v%0d_busy_end", i), {31'h0, busy}, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'h0, done}, 32'h0);
            chk($sformatf("v%0d_hold", i), {16'h0, out}, {16'h0, vecs[i].res});
        end

        // AND pulsed while multiplying is ignored; ADD held in the done cycle is taken.
        issue(OP_MUL, 16'h0123, 16'h0045);
        repeat (4) begin @(posedge clk); #1; end
        chk("seq_busy_mid", {31'h0, busy}, 32'h1);
        @(negedge clk);
        alu_op = OP_AND; x = 16'hFFFF; y = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("seq_ignored_no_done", {31'h0, done}, 32'h0);
        wait_done(n);
        total = 5 + n;
        chk("seq_mul_edges", total, 16);
        chk("seq_mul_out", {16'h0, out}, 32'h4E6F);
        chk("seq_mul_gt", {29'h0, lt, eq, gt}, 32'h1);
        alu_op = OP_ADD; x = 16'h0002; y = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("seq_b2b_done", {31'h0, done}, 32'h1);
        chk("seq_b2b_out", {16'h0, out}, 32'h0005);

        // Back-to-back single-cycle ops.
        issue(OP_OR, 16'hF0F0, 16'h0F0F);
        chk("b2b1_out", {15'h0, done, out}, {15'h0, 1'b1, 16'hFFFF});
        alu_op = OP_AND; x = 16'hFFFF; y = 16'h00FF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b2_out", {15'h0, done, out}, {15'h0, 1'b1, 16'h00FF});
        @(posedge clk);
        #1;
        chk("b2b2_done_drop", {31'h0, done}, 32'h0);

        // Reset at multiply cycle 8 aborts with no done.
        issue(OP_MUL, 16'h0123, 16'h0045);
        repeat (7) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out", {16'h0, out}, 32'h0);
        chk("abort_flags", {27'h0, lt, eq, gt, carry_out, overflow}, 32'h0);
        chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        issue(OP_ADD, 16'h0002, 16'h0003);
        wait_done(n);
        chk("abort_add_edges", n, 0);
        chk("abort_add_out", {16'h0, out}, 32'h0005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; legal values 8, 16, 32.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  in  1  request; sampled on rising clk edge, accepted only when busy=0.
REQ-005 alu_op  in  3  operation, captured with start.
REQ-006 x  in  WIDTH  operand A, captured with start.
REQ-007 y  in  WIDTH  operand B, captured with start.
REQ-008 busy  out  1  multiply in progress; new start ignored.
REQ-009 done  out  1  one-cycle pulse; out and flags updated this cycle.
REQ-010 out  out  WIDTH  registered result.
REQ-011 lt, eq, gt  out  1 each  registered unsigned compare of captured x vs y.
REQ-012 carry_out, overflow  out  1 each  registered add/sub flags.

Function
REQ-013 alu_op encoding: 0 AND, 1 OR, 2 ADD, 3 SLT, 4 SLL, 5 SRL, 6 SUB, 7 MUL.
REQ-014 ADD: out = (x+y) mod 2^WIDTH; carry_out = bit WIDTH of the sum; overflow = signed two's-complement overflow.
REQ-015 SUB: out = x + ~y + 1; carry_out = 1 when no borrow (x>=y unsigned); overflow = signed overflow.
REQ-016 SLT: out = zero-extended (x<y unsigned).
REQ-017 SLL/SRL: logical shift of x by y[clog2(WIDTH)-1:0]; upper y bits are ignored; zero fill.
REQ-018 MUL: out = low WIDTH bits of the unsigned x*y, computed by iterative shift-add, one partial product per cycle.
REQ-019 carry_out and overflow = 0 for every op except ADD/SUB.
REQ-020 lt/eq/gt are computed for every op; exactly one is 1 at each done.
REQ-021 FSM states: IDLE, MUL.
- IDLE + start with op 0-6: result registered at the same edge; done=1 next cycle (latency 1); remain IDLE.
- IDLE + start with op 7: go to MUL and set busy=1.
REQ-022 MUL: iterate at WIDTH consecutive edges; at the WIDTH-th edge, write out/flags, set done=1 and busy=0, and return to IDLE (latency WIDTH cycles from the accept edge).
REQ-023 start while busy=1 is ignored, and operands are not recaptured.
REQ-024 start is accepted in the cycle where done=1 (back-to-back); done is then 1 again next cycle for ops 0-6.
REQ-025 out and flags hold their value between done pulses; input changes after capture have no effect.
REQ-026 done is never high for two consecutive cycles from a single request.

Reset
REQ-027 On rst=1: state=IDLE, busy=0, done=0, out=0, lt=eq=gt=0, carry_out=0, overflow=0, and the multiply counter/accumulator is cleared.
REQ-028 rst during MUL aborts the operation; no done is produced for it.
REQ-029 start coincident with rst is ignored.

Verification (WIDTH=16)
REQ-030 ADD x=0xFFFF, y=0x0001 -> next cycle: done=1, out=0x0000, carry_out=1, overflow=0, gt=1.
REQ-031 SUB x=0x8000, y=0x0001 -> out=0x7FFF, carry_out=1, overflow=1; SLT x=3, y=5 -> out=0x0001, lt=1.
REQ-032 MUL x=0x0123, y=0x0045 -> busy high for 16 cycles, done exactly 16 cycles after the accept edge, out=0x4E6F; MUL 0xFFFF*0xFFFF -> out=0x0001, carry_out=0, overflow=0.
REQ-033 start with AND pulsed during MUL busy -> ignored, MUL result intact; start held in the done cycle -> accepted, second done one cycle later.
REQ-034 rst asserted at MUL cycle 8 -> all outputs zero next cycle, no done; new ADD 2+3 afterwards -> out=0x0005.
REQ-035 SLL x=0x0001, y=0x0013 -> out=0x0008 (shift 3); SRL x=0x8000, y=0x000F -> out=0x0001.
